// File: rtl/simon_sound.sv
// Speaker driver for the Simon game: per-button tones while a lamp is lit and
// fixed win / lose / high-score jingles triggered by status edges.
module simon_sound #(
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned HP0      = 113636,
    parameter int unsigned HP1      = 90193,
    parameter int unsigned HP2      = 75843,
    parameter int unsigned HP3      = 56818,
    parameter int unsigned HP_LOSE  = 227272,
    parameter int unsigned NOTE_LEN = 'h7FFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tone_sel,
    input  logic       tone_ena,
    input  logic       win,
    input  logic       lose,
    input  logic       hs,
    output logic       spk,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle,
        StTone,
        StJingle
    } state_e;

    // Numeric order of the jingle kinds is their preemption priority.
    typedef enum logic [1:0] {
        KindNone = 2'd0,
        KindHs   = 2'd1,
        KindWin  = 2'd2,
        KindLose = 2'd3
    } kind_e;

    localparam logic [CNT_W-1:0] HpLim0    = CNT_W'(HP0 - 1);
    localparam logic [CNT_W-1:0] HpLim1    = CNT_W'(HP1 - 1);
    localparam logic [CNT_W-1:0] HpLim2    = CNT_W'(HP2 - 1);
    localparam logic [CNT_W-1:0] HpLim3    = CNT_W'(HP3 - 1);
    localparam logic [CNT_W-1:0] HpLimLose = CNT_W'(HP_LOSE - 1);
    localparam logic [CNT_W-1:0] NoteLim   = CNT_W'(NOTE_LEN - 1);

    function automatic logic [CNT_W-1:0] tone_lim(input logic [1:0] sel);
        logic [CNT_W-1:0] lim;
        unique case (sel)
            2'd0:    lim = HpLim0;
            2'd1:    lim = HpLim1;
            2'd2:    lim = HpLim2;
            default: lim = HpLim3;
        endcase
        return lim;
    endfunction

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d;
    logic [1:0]       slot_q, slot_d;
    logic [CNT_W-1:0] note_q, note_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic             spk_q, spk_d;
    logic [1:0]       tone_cur_q, tone_cur_d;

    logic [1:0] sel_q;
    logic       ena_q;
    logic       win_q, win_qq;
    logic       lose_q, lose_qq;
    logic       hs_q, hs_qq;
    logic       primed_q;

    kind_e            ev_kind;
    logic [CNT_W-1:0] hp_lim;
    logic             rest;
    logic             note_start;
    logic             note_run;

    always_comb begin
        ev_kind = KindNone;
        if (hs_q && !hs_qq) begin
            ev_kind = KindHs;
        end
        if (win_q && !win_qq) begin
            ev_kind = KindWin;
        end
        if (lose_q && !lose_qq) begin
            ev_kind = KindLose;
        end
    end

    always_comb begin
        hp_lim = tone_lim(tone_cur_q);
        rest   = 1'b0;
        if (state_q == StJingle) begin
            case (kind_q)
                KindLose: hp_lim = HpLimLose;
                KindWin:  hp_lim = tone_lim(slot_q);
                default: begin
                    hp_lim = HpLim3;
                    rest   = slot_q[0];
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        slot_d     = slot_q;
        note_d     = note_q;
        tone_cur_d = tone_cur_q;
        note_start = 1'b0;
        note_run   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ev_kind != KindNone) begin
                    state_d    = StJingle;
                    kind_d     = ev_kind;
                    slot_d     = 2'd0;
                    note_d     = '0;
                    note_start = 1'b1;
                end else if (ena_q) begin
                    state_d    = StTone;
                    tone_cur_d = sel_q;
                    note_start = 1'b1;
                end
            end
            StTone: begin
                if (ev_kind != KindNone) begin
                    state_d    = StJingle;
                    kind_d     = ev_kind;
                    slot_d     = 2'd0;
                    note_d     = '0;
                    note_start = 1'b1;
                end else if (!ena_q) begin
                    state_d = StIdle;
                end else if (sel_q != tone_cur_q) begin
                    tone_cur_d = sel_q;
                    note_start = 1'b1;
                end else begin
                    note_run = 1'b1;
                end
            end
            StJingle: begin
                if (ev_kind > kind_q) begin
                    kind_d     = ev_kind;
                    slot_d     = 2'd0;
                    note_d     = '0;
                    note_start = 1'b1;
                end else if (note_q == NoteLim) begin
                    note_d = '0;
                    if (slot_q == 2'd3) begin
                        if (ena_q) begin
                            state_d    = StTone;
                            tone_cur_d = sel_q;
                            note_start = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        slot_d     = slot_q + 2'd1;
                        note_start = 1'b1;
                    end
                end else begin
                    note_d   = note_q + 1'b1;
                    note_run = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hp_d  = hp_q;
        spk_d = spk_q;
        if (note_start || state_d == StIdle) begin
            hp_d  = '0;
            spk_d = 1'b0;
        end else if (note_run) begin
            if (rest) begin
                hp_d  = '0;
                spk_d = 1'b0;
            end else if (hp_q == hp_lim) begin
                hp_d  = '0;
                spk_d = ~spk_q;
            end else begin
                hp_d = hp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            kind_q     <= KindNone;
            slot_q     <= 2'd0;
            note_q     <= '0;
            hp_q       <= '0;
            spk_q      <= 1'b0;
            tone_cur_q <= 2'd0;
            sel_q      <= 2'd0;
            ena_q      <= 1'b0;
            win_q      <= 1'b0;
            win_qq     <= 1'b0;
            lose_q     <= 1'b0;
            lose_qq    <= 1'b0;
            hs_q       <= 1'b0;
            hs_qq      <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            slot_q     <= slot_d;
            note_q     <= note_d;
            hp_q       <= hp_d;
            spk_q      <= spk_d;
            tone_cur_q <= tone_cur_d;
            sel_q      <= tone_sel;
            ena_q      <= tone_ena;
            win_q      <= win;
            lose_q     <= lose;
            hs_q       <= hs;
            // First cycle out of reset seeds both stages so a held level is no edge.
            win_qq     <= primed_q ? win_q : win;
            lose_qq    <= primed_q ? lose_q : lose;
            hs_qq      <= primed_q ? hs_q : hs;
            primed_q   <= 1'b1;
        end
    end

    assign spk  = spk_q;
    assign busy = (state_q == StJingle);

endmodule

// File: tb/tb_simon_sound.sv
// Bench for simon_sound: directed scenarios plus random traffic, compared every
// cycle against a timeline model of the expected speaker and busy outputs.
module tb_simon_sound;

    localparam int NL = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tone_sel = 2'd0;
    logic       tone_ena = 1'b0;
    logic       win = 1'b0;
    logic       lose = 1'b0;
    logic       hs = 1'b0;
    logic       spk;
    logic       busy;

    simon_sound #(
        .CNT_W(8), .HP0(4), .HP1(5), .HP2(6), .HP3(7), .HP_LOSE(10), .NOTE_LEN(NL)
    ) dut (
        .clk(clk), .rst(rst), .tone_sel(tone_sel), .tone_ena(tone_ena),
        .win(win), .lose(lose), .hs(hs), .spk(spk), .busy(busy)
    );

    always #5 clk = ~clk;

    // Timeline model: mode 0 idle, 1 tone, 2 jingle; kind 1 hs, 2 win, 3 lose.
    int hp_tab [4] = '{4, 5, 6, 7};
    int n = 0;
    int mode = 0, kind = 0, t0 = 0, cur_sel = 0;
    bit primed = 0;
    bit win_r, win_rr, lose_r, lose_rr, hs_r, hs_rr, ena_r;
    int sel_r;
    logic exp_spk = 1'b0, exp_busy = 1'b0;

    always @(posedge clk) begin
        int ev, k, slot, hp;
        n++;
        if (rst) begin
            mode = 0; primed = 0;
            win_r = 0; win_rr = 0; lose_r = 0; lose_rr = 0; hs_r = 0; hs_rr = 0;
            ena_r = 0; sel_r = 0;
        end else begin
            ev = 0;
            if (hs_r && !hs_rr) ev = 1;
            if (win_r && !win_rr) ev = 2;
            if (lose_r && !lose_rr) ev = 3;
            case (mode)
                0: begin
                    if (ev != 0) begin mode = 2; kind = ev; t0 = n; end
                    else if (ena_r) begin mode = 1; cur_sel = sel_r; t0 = n; end
                end
                1: begin
                    if (ev != 0) begin mode = 2; kind = ev; t0 = n; end
                    else if (!ena_r) mode = 0;
                    else if (sel_r != cur_sel) begin cur_sel = sel_r; t0 = n; end
                end
                default: begin
                    if (ev > kind) begin kind = ev; t0 = n; end
                    else if (n - t0 == 4 * NL) begin
                        if (ena_r) begin mode = 1; cur_sel = sel_r; t0 = n; end
                        else mode = 0;
                    end
                end
            endcase
            win_rr = primed ? win_r : win;   win_r = win;
            lose_rr = primed ? lose_r : lose; lose_r = lose;
            hs_rr = primed ? hs_r : hs;      hs_r = hs;
            ena_r = tone_ena; sel_r = int'(tone_sel); primed = 1;
        end
        k = n - t0;
        exp_busy = (mode == 2);
        exp_spk = 1'b0;
        if (mode == 1) begin
            exp_spk = ((k / hp_tab[cur_sel]) % 2) == 1;
        end else if (mode == 2) begin
            slot = k / NL;
            if (kind == 3) hp = 10;
            else if (kind == 2) hp = hp_tab[slot];
            else hp = (slot % 2 == 1) ? 0 : 7;
            exp_spk = (hp != 0) && (((k % NL) / hp) % 2 == 1);
        end
    end

    int n_assert = 0;
    int n_fail = 0;
    int busy_cnt = 0;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, expv, n);
        end
    endtask

    task automatic tick(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("spk", spk, exp_spk);
            check("busy", busy, exp_busy);
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic pulse_win();
        win = 1'b1; tick(1); win = 1'b0;
    endtask

    initial begin
        int bound;
        // Reset, with a tone request already pending.
        tone_sel = 2'd2; tone_ena = 1'b1;
        tick(3);
        check("reset_spk", spk, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick(60);
        tone_ena = 1'b0;
        tick(2);
        check("tone_off_spk", spk, 1'b0);
        tick(4);

        // WIN jingle from idle.
        busy_cnt = 0;
        pulse_win();
        tick(140);
        check("win_busy_len", busy_cnt == 128, 1'b1);
        check("win_end_busy", busy, 1'b0);

        // HS jingle with rests.
        hs = 1'b1; tick(1); hs = 1'b0;
        tick(140);

        // WIN preempts HS at cycle 40.
        hs = 1'b1; tick(1); hs = 1'b0;
        tick(40);
        busy_cnt = 0;
        pulse_win();
        tick(140);
        check("preempt_busy_len", busy_cnt > 128, 1'b1);

        // HS ignored during LOSE.
        busy_cnt = 0;
        lose = 1'b1; tick(1); lose = 1'b0;
        tick(20);
        hs = 1'b1; tick(1); hs = 1'b0;
        tick(130);
        check("lose_busy_len", busy_cnt == 128, 1'b1);

        // Simultaneous win+lose with tone held: LOSE, then tone resumes.
        tone_sel = 2'd1; tone_ena = 1'b1;
        tick(10);
        win = 1'b1; lose = 1'b1; tick(1); win = 1'b0; lose = 1'b0;
        tick(150);
        tone_ena = 1'b0;
        tick(5);

        // Reset mid-WIN, win held across release.
        pulse_win();
        tick(50);
        rst = 1'b1; win = 1'b1;
        tick(1);
        check("rst_spk", spk, 1'b0);
        check("rst_busy", busy, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("held_win_no_jingle", busy, 1'b0);
        win = 1'b0;
        tick(5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            win  = ($urandom_range(0, 99) < 2);
            lose = ($urandom_range(0, 99) < 1);
            hs   = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 29) == 0) tone_ena = ~tone_ena;
            if ($urandom_range(0, 19) == 0) tone_sel = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 799) == 0);
            tick(1);
        end
        win = 1'b0; lose = 1'b0; hs = 1'b0; rst = 1'b0; tone_ena = 1'b0;

        // Bounded wait for the last jingle to finish.
        bound = 0;
        while (busy !== 1'b0 && bound < 200) begin
            tick(1);
            bound++;
        end
        check("final_idle", busy, 1'b0);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
